div_sched: RTL
==============

Name: div_sched

Overview:
- Round-robin scheduler that shares one 32-bit unsigned sequential divider among NREQ requesters, e.g. the calculator ALU and the binary-to-BCD display converter.
- Accepts one request at a time and launches the divider by holding its level-sensitive start high.
- Captures quotient and remainder in the single cycle the divider flags completion.
- Returns the result on a shared response channel tagged with the requester id.
- Sits between the requesters and the divider instance.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester id; must be at least clog2(NREQ)
TIMEOUT, 48, max cycles in BUSY before forced abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  one-hot accept; at most one bit high
req_a  in  32*NREQ  dividends; slice i = bits [32i+31:32i]
req_b  in  32*NREQ  divisors, sliced as req_a
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester index of the response
rsp_q  out  32  quotient
rsp_r  out  32  remainder
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
div_start  out  1  divider start; held high for the whole operation
div_a  out  32  registered dividend to divider
div_b  out  32  registered divisor to divider
div_d  in  32  divider quotient
div_r  in  32  divider remainder
div_ok  in  1  divider ready/done flag

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, and every output 0. This includes req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_start, div_a and div_b.
- States: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - Combinational one-hot req_ready to the first req_valid found searching from rr_ptr upward, wrapping modulo NREQ.
  - Zero requesters valid: req_ready=0.
  - On handshake from requester g: latch g, div_a=a_g, div_b=b_g.
  - If b_g==0: go to RESP with rsp_err=01, rsp_q=32'hFFFFFFFF, rsp_r=a_g. The divider is not started.
  - Otherwise: go to LAUNCH with div_start=1.
  - rr_ptr becomes (g+1) mod NREQ on every grant.
- LAUNCH: div_start held 1. div_ok is high for the first cycle because the divider is still idle, so it is ignored. Wait for div_ok=0, then go to BUSY.
- BUSY:
  - div_start held 1; timeout counter increments.
  - First cycle with div_ok=1: capture rsp_q=div_d, rsp_r=div_r, rsp_err=00, drop div_start to 0, go to RESP.
  - div_start must fall in the same cycle as the capture. The divider auto-restarts one cycle after done.
  - Counter reaching TIMEOUT: rsp_err=10, rsp_q=0, rsp_r=0, div_start=0, go to RESP.
- RESP: rsp_valid=1 and rsp_id=g. rsp_q, rsp_r, rsp_err and rsp_id are held stable until rsp_ready=1. On handshake: rsp_valid=0, go to IDLE.
- Handshake rules:
  - req_ready is never asserted outside IDLE, so there is no new grant while a response is pending.
  - Request and response never complete in the same cycle.
- Latency:
  - Zero-divisor path: rsp_valid is asserted 1 cycle after the accepting edge.
  - Normal path: rsp_valid is asserted the cycle after div_ok rises in BUSY. With the team divider this is 34 cycles after acceptance.
  - Occupancy between grants is at least 36 cycles with rsp_ready tied high.
- Arithmetic: unsigned only. Invariant: q*b + r == a with r < b.
- Reset mid-operation clears state immediately. Because div_start drops, the divider is cleared too. Any response not yet handshaked is discarded.
- A requester dropping req_valid before grant is legal and is simply skipped.
- req_a and req_b are sampled only at the handshake edge.

Test Plan:
- Req0 with a=100, b=7, rsp_ready=1 -> rsp_id=0, q=14, r=2, err=00, rsp_valid asserted 34 cycles after acceptance; div_start high only during LAUNCH/BUSY.
- Req2 with a=5, b=0 -> rsp_valid on the next cycle, err=01, q=FFFFFFFF, r=5, div_start never asserted.
- All four requesters valid at once with distinct operands (e.g. 0xFFFFFFFF/1, 1000/10, 7/9, 0x80000000/3) -> grants in order 0,1,2,3; results FFFFFFFF/0, 100/0, 0/7, 2AAAAAAA/2; a second wave is served 0,1,2,3 again.
- Hold rsp_ready=0 for 20 cycles after rsp_valid -> outputs stable, no req_ready asserted; release -> one handshake, then the next grant.
- Assert reset low 10 cycles into BUSY -> all outputs 0 immediately, div_start=0; after release, a new 100/7 request completes correctly.
- Divider model with div_ok stuck low after LAUNCH -> err=10 after TIMEOUT cycles, q=r=0, div_start=0, scheduler returns to IDLE.

Source files
------------

// File: rtl/div_sched_if.sv
// Port bundle for div_sched: the requester channels, the shared response
// channel and the link to the divider it schedules.
interface div_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_q;
    logic [31:0]          rsp_r;
    logic [1:0]           rsp_err;
    logic                 div_start;
    logic [31:0]          div_a;
    logic [31:0]          div_b;
    logic [31:0]          div_d;
    logic [31:0]          div_r;
    logic                 div_ok;

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, div_d, div_r, div_ok,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );

    // Requesters, response consumer and divider as seen from outside.
    modport master (
        output req_valid, req_a, req_b, rsp_ready, div_d, div_r, div_ok,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
               div_start, div_a, div_b
    );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one 32-bit unsigned sequential divider
// among NREQ requesters; results return on one response channel tagged
// with the requester id.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrating; req_ready offered to the round-robin winner
// LAUNCH  | div_start high, waiting for the divider to drop div_ok
// BUSY    | divider running; capture on div_ok or abort on timeout
// RESP    | rsp_valid high, result held until rsp_ready
module div_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 48
) (
    input  logic       clk,
    input  logic       reset,
    div_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_q;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  ptr_next;
    logic [IDW:0]    ptr_inc;
    logic            found;
    logic            hs_req;
    logic [NREQ-1:0] rdy;
    logic [31:0]     a_arr [NREQ];
    logic [31:0]     b_arr [NREQ];
    logic [31:0]     a_sel;
    logic [31:0]     b_sel;
    logic [TW-1:0]   tmr;

    logic            div_start_reg;
    logic [31:0]     div_a_reg;
    logic [31:0]     div_b_reg;
    logic            rsp_valid_reg;
    logic [31:0]     rsp_q_reg;
    logic [31:0]     rsp_r_reg;
    logic [1:0]      rsp_err_reg;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_arr[i] = bus.req_a[32*i +: 32];
        assign b_arr[i] = bus.req_b[32*i +: 32];
    end

    assign a_sel = a_arr[gnt_idx];
    assign b_sel = b_arr[gnt_idx];

    // Round-robin pick: first valid at or above rr_ptr, else first valid below it.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && i >= int'(rr_ptr) && bus.req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end

    // Grant is offered only in IDLE and never while reset is asserted.
    always_comb begin
        hs_req = reset && (state == S_IDLE) && found;
        rdy    = '0;
        if (hs_req) begin
            rdy[gnt_idx] = 1'b1;
        end
    end

    // Next round-robin pointer, one past the winner modulo NREQ.
    always_comb begin
        ptr_inc  = {1'b0, gnt_idx} + 1'b1;
        ptr_next = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
    end

    // Scheduler FSM, divider launch and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            gnt_q         <= '0;
            tmr           <= '0;
            div_start_reg <= 1'b0;
            div_a_reg     <= '0;
            div_b_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_q_reg     <= '0;
            rsp_r_reg     <= '0;
            rsp_err_reg   <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs_req) begin
                        gnt_q     <= gnt_idx;
                        rr_ptr    <= ptr_next;
                        div_a_reg <= a_sel;
                        div_b_reg <= b_sel;
                        if (b_sel == '0) begin
                            // Divide-by-zero is answered locally; the divider is never started.
                            rsp_q_reg     <= '1;
                            rsp_r_reg     <= a_sel;
                            rsp_err_reg   <= ERR_DIV0;
                            rsp_valid_reg <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            div_start_reg <= 1'b1;
                            state         <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    // div_ok is still high from the idle divider; wait until it takes the job.
                    if (!bus.div_ok) begin
                        tmr   <= TW'(TIMEOUT - 1);
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.div_ok) begin
                        // Start must fall on the capture edge or the divider restarts.
                        rsp_q_reg     <= bus.div_d;
                        rsp_r_reg     <= bus.div_r;
                        rsp_err_reg   <= ERR_OK;
                        div_start_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state         <= S_RESP;
                    end else if (tmr == '0) begin
                        rsp_q_reg     <= '0;
                        rsp_r_reg     <= '0;
                        rsp_err_reg   <= ERR_TMO;
                        div_start_reg <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = rdy;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = gnt_q;
    assign bus.rsp_q     = rsp_q_reg;
    assign bus.rsp_r     = rsp_r_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.div_start = div_start_reg;
    assign bus.div_a     = div_a_reg;
    assign bus.div_b     = div_b_reg;
endmodule
